// File: rtl/rom_pkg.sv
// Shared definitions for the ROM read sequencer and the ROM it drives.
package rom_pkg;

  localparam int ROM_DEPTH  = 8;
  localparam int ROM_ADDR_W = 3;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_READ,
    RD_CAPTURE,
    RD_HOLD,
    RD_FIN
  } rom_rd_state_t;

  // A request longer than the ROM is clipped to one full pass over it.
  function automatic logic [3:0] sat_len(input logic [3:0] len);
    return (len > 4'(ROM_DEPTH)) ? 4'(ROM_DEPTH) : len;
  endfunction

endpackage

// File: rtl/rom_reader_if.sv
// Valid/ready word stream leaving the ROM reader.
interface rom_reader_if #(
  parameter int data_width = 8
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/rom.sv
// 8-entry ROM with a one-cycle registered read; entry i holds i+1.
// The output register only updates while en is high, so it holds its word otherwise.
module rom
  import rom_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [data_width-1:0] rom_out
);

  // Registered read of the addressed word, held while disabled.
  always_ff @(posedge clock) begin
    if (en) begin
      rom_out <= data_width'(addr) + data_width'(1);
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Read sequencer: walks a wrap-around address range of the attached ROM,
// absorbs its one-cycle read latency and streams each word on a valid/ready port.
module rom_reader
  import rom_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ROM_ADDR_W-1:0] base_addr,
  input  logic [3:0]            length,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [data_width-1:0] rom_data,
  rom_reader_if.master          out_if
);

  rom_rd_state_t         state_q, state_d;
  logic [ROM_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]            remaining_q, remaining_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [3:0]            eff_len;

  assign eff_len = sat_len(length);

  // Next-state and datapath updates for the read/capture/hold sequence.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      RD_IDLE: begin
        if (start) begin
          if (eff_len == 4'd0) begin
            state_d = RD_FIN;
          end else begin
            cur_addr_d  = base_addr;
            remaining_d = eff_len;
            state_d     = RD_READ;
          end
        end
      end
      RD_READ: begin
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        out_data_d  = rom_data;
        out_last_d  = (remaining_q == 4'd1);
        out_valid_d = 1'b1;
        state_d     = RD_HOLD;
      end
      RD_HOLD: begin
        if (out_valid_q && out_if.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          remaining_d = remaining_q - 4'd1;
          if (out_last_q) begin
            state_d = RD_FIN;
          end else begin
            cur_addr_d = cur_addr_q + ROM_ADDR_W'(1);
            state_d    = RD_READ;
          end
        end
      end
      RD_FIN: begin
        state_d = RD_IDLE;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RD_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy     = (state_q != RD_IDLE);
  assign done     = (state_q == RD_FIN);
  assign rom_en   = (state_q == RD_READ);
  assign rom_addr = rom_en ? cur_addr_q : '0;

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader paired with an 8-entry rom (entry i holds i+1).
module tb_rom_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] length;
  logic       busy;
  logic       done;
  logic       rom_en;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;

  rom_reader_if #(.data_width(8)) rif ();

  rom_reader #(.data_width(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_if    (rif.master)
  );

  rom #(.data_width(8)) u_rom (
    .clock   (clock),
    .en      (rom_en),
    .addr    (rom_addr),
    .rom_out (rom_data)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] gotWords [16];
  logic       gotLast [16];
  int         gotCycle [16];
  int         gotCount;
  int         doneCycle;
  int         romEnCount;
  int         validCycles;
  bit         doneSeen;

  function automatic logic [15:0] allOutputs();
    return {busy, done, rom_en, rom_addr, rif.out_valid, rif.out_last, rif.out_data};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one command, then sample once per cycle until done (or budget expires).
  task automatic applyStimulus(input logic [2:0] base, input logic [3:0] len, input int stallWord,
                               input int stallCycles, input logic [7:0] stallExpect,
                               input bit reStart, input int budget);
    int cycle;
    int stallLeft;
    gotCount    = 0;
    doneCycle   = -1;
    romEnCount  = 0;
    validCycles = 0;
    doneSeen    = 0;
    stallLeft   = stallCycles;
    base_addr   = base;
    length      = len;
    start       = 1'b1;
    rif.out_ready = 1'b1;
    stepCycle();
    start = 1'b0;
    cycle = 1;
    while (!doneSeen && cycle <= budget) begin
      if (reStart && cycle == 1) begin
        start     = 1'b1;
        base_addr = 3'd0;
        length    = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (rom_en) romEnCount++;
      if (done) begin
        doneSeen  = 1;
        doneCycle = cycle;
      end
      if (rif.out_valid) begin
        validCycles++;
        if (gotCount == stallWord && stallLeft > 0) begin
          rif.out_ready = 1'b0;
          stallLeft--;
          checkOutput("stall_hold_data", rif.out_data, stallExpect);
        end else begin
          rif.out_ready = 1'b1;
          if (gotCount < 16) begin
            gotWords[gotCount] = rif.out_data;
            gotLast[gotCount]  = rif.out_last;
            gotCycle[gotCount] = cycle;
          end
          gotCount++;
        end
      end else begin
        rif.out_ready = 1'b1;
      end
      if (!doneSeen) begin
        stepCycle();
        cycle++;
      end
    end
    start = 1'b0;
    checkOutput("done_within_budget", 32'(doneSeen), 1);
    stepCycle();
    checkOutput("busy_low_after_done", busy, 0);
  endtask

  logic [7:0] exp2 [3] = '{8'h03, 8'h04, 8'h05};
  logic [7:0] exp3 [8] = '{8'h07, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

  // Linear sequence of directed scenarios followed by the summary line.
  initial begin
    logic [15:0] accum;

    reset_n       = 1'b0;
    start         = 1'b0;
    base_addr     = 3'd0;
    length        = 4'd0;
    rif.out_ready = 1'b0;

    $display("[TB] scenario 1: reset then idle");
    #2;
    checkOutput("reset_outputs", allOutputs(), 0);
    stepCycle();
    stepCycle();
    reset_n = 1'b1;
    accum = '0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      accum = accum | allOutputs();
    end
    checkOutput("idle_outputs_zero", accum, 0);

    $display("[TB] scenario 2: base 2 length 3");
    applyStimulus(3'd2, 4'd3, -1, 0, 8'h00, 0, 40);
    checkOutput("s2_count", gotCount, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("s2_word%0d", i), gotWords[i], exp2[i]);
      checkOutput($sformatf("s2_cycle%0d", i), gotCycle[i], 3 * (i + 1));
      checkOutput($sformatf("s2_last%0d", i), gotLast[i], (i == 2) ? 1 : 0);
    end
    checkOutput("s2_done_cycle", doneCycle, 10);
    checkOutput("s2_rom_en_count", romEnCount, 3);

    $display("[TB] scenario 3: wrap and saturation");
    applyStimulus(3'd6, 4'd12, -1, 0, 8'h00, 0, 60);
    checkOutput("s3_count", gotCount, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s3_word%0d", i), gotWords[i], exp3[i]);
      checkOutput($sformatf("s3_last%0d", i), gotLast[i], (i == 7) ? 1 : 0);
    end
    checkOutput("s3_done_cycle", doneCycle, 25);
    checkOutput("s3_rom_en_count", romEnCount, 8);

    $display("[TB] scenario 4: backpressure");
    applyStimulus(3'd0, 4'd2, 0, 5, 8'h01, 0, 60);
    checkOutput("s4_count", gotCount, 2);
    checkOutput("s4_word0", gotWords[0], 8'h01);
    checkOutput("s4_word1", gotWords[1], 8'h02);
    checkOutput("s4_cycle0", gotCycle[0], 8);
    checkOutput("s4_cycle1", gotCycle[1], 11);
    checkOutput("s4_last1", gotLast[1], 1);
    checkOutput("s4_done_cycle", doneCycle, 12);
    checkOutput("s4_rom_en_count", romEnCount, 2);
    checkOutput("s4_valid_cycles", validCycles, 7);

    $display("[TB] scenario 5: zero length and ignored start");
    applyStimulus(3'd3, 4'd0, -1, 0, 8'h00, 0, 10);
    checkOutput("s5_done_cycle", doneCycle, 1);
    checkOutput("s5_rom_en_count", romEnCount, 0);
    checkOutput("s5_valid_cycles", validCycles, 0);
    applyStimulus(3'd2, 4'd1, -1, 0, 8'h00, 1, 20);
    checkOutput("s5b_count", gotCount, 1);
    checkOutput("s5b_word0", gotWords[0], 8'h03);
    checkOutput("s5b_done_cycle", doneCycle, 4);
    checkOutput("s5b_rom_en_count", romEnCount, 1);
    accum = '0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      accum = accum | {13'd0, busy, rom_en, done};
    end
    checkOutput("s5b_stays_idle", accum, 0);

    $display("[TB] scenario 6: reset during hold");
    base_addr     = 3'd3;
    length        = 4'd2;
    start         = 1'b1;
    rif.out_ready = 1'b0;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("s6_hold_valid", rif.out_valid, 1);
    checkOutput("s6_hold_data", rif.out_data, 8'h04);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("s6_async_reset_outputs", allOutputs(), 0);
    accum = '0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      accum = accum | allOutputs();
    end
    checkOutput("s6_no_done_in_reset", accum, 0);
    reset_n = 1'b1;
    stepCycle();
    applyStimulus(3'd5, 4'd1, -1, 0, 8'h00, 0, 20);
    checkOutput("s6_count", gotCount, 1);
    checkOutput("s6_word0", gotWords[0], 8'h06);
    checkOutput("s6_last0", gotLast[0], 1);
    checkOutput("s6_done_cycle", doneCycle, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_reader.md
# rom_reader

Read sequencer that sits directly upstream of the 8-entry `rom` block and streams its contents to a downstream consumer. On a `start` pulse it walks a contiguous, wrap-around address range in the ROM by driving the ROM's `en`/`addr` inputs. It accounts for the ROM's one-cycle registered read latency and presents each word on a valid/ready output port. It completes with a single `done` pulse.

## Interface
- `data_width`, default 8: ROM word width; must match the attached `rom` instance.
- `clock`  in  1: rising-edge clock shared with `rom`.
- `reset_n`  in  1: asynchronous, active-low reset. This is the block's only clock and only reset.
- `start`  in  1: single-cycle request, sampled only in IDLE.
- `base_addr`  in  3: first ROM address, sampled with `start`.
- `length`  in  4: words to read, sampled with `start`. 0 means no transfer; 9..15 saturate to 8.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a command completes.
- `rom_en`  out  1: drives `rom.en`.
- `rom_addr`  out  3: drives `rom.addr`.
- `rom_data`  in  data_width: from `rom.rom_out`.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  data_width: registered ROM word.
- `out_last`  out  1: qualifies the final word of a command; valid only while `out_valid` is high.

## Operation
- State machine states: IDLE, READ, CAPTURE, HOLD, FIN.
- **IDLE**
  - On `start` with effective length N ≥ 1: latch `cur_addr` = `base_addr` and `remaining` = N (4-bit). Go to READ.
  - On `start` with `length` = 0: go to FIN.
- **READ** (exactly 1 cycle): `rom_en` = 1, `rom_addr` = `cur_addr`. Go to CAPTURE.
- **CAPTURE** (exactly 1 cycle)
  - `rom_en` = 0; `rom_data` now holds the word.
  - Load `out_data` ← `rom_data`, `out_last` ← (`remaining` == 1), set `out_valid`.
  - Go to HOLD.
- **HOLD**
  - `out_valid` = 1. `out_data` and `out_last` stay stable until the handshake.
  - On `out_valid && out_ready`: clear `out_valid` and decrement `remaining`.
    - If `out_last`: go to FIN.
    - Otherwise: `cur_addr` ← `cur_addr` + 1 mod 8 (7 wraps to 0), go to READ.
- **FIN** (exactly 1 cycle): `done` = 1. Go to IDLE.
- `start` outside IDLE is ignored. There is no abort input.
- `rom_en` is asserted only in READ. The ROM holds its output while `en` = 0, so stalls in HOLD never disturb `rom_data`.
- Reset values (async assert, any state): state = IDLE, and `busy`, `done`, `rom_en`, `out_valid`, `out_last` = 0. `rom_addr`, `out_data`, `cur_addr` = 0. `remaining` = 0.
- Reset mid-command drops the in-flight word; no `done` is issued. Reset deassertion is expected to be synchronised externally.

## Timing
- `start` sampled at edge 0 → READ in cycle 1 → CAPTURE in cycle 2 → `out_valid` high from cycle 3.
- With `out_ready` held high, one word every 3 cycles. An N-word command has `done` high in cycle 3N+1 and `busy` low again in cycle 3N+2.
- `length` = 0: `done` high in cycle 1 (FIN); `rom_en` never asserted.
- Stalls: each cycle that `out_ready` is low in HOLD adds one cycle. No word is lost or repeated.
- All outputs are registered or decoded from the state register. There is no combinational path from `out_ready` to any output.

## Structure
- Shared package `rom_pkg`:
  - `ROM_DEPTH` = 8 and `ROM_ADDR_W` = 3.
  - `rom_rd_state_t` enum covering IDLE, READ, CAPTURE, HOLD, FIN.
  - A `sat_len` function that maps 0..15 to 0..8.
- No sub-module inside `rom_reader`. Integration pairs it 1:1 with `rom`, wiring `rom_en`/`rom_addr`/`rom_data` directly.

## Test plan
ROM contents: entry i holds i+1. Each scenario instantiates `rom_reader` together with `rom`.
1. Reset then idle: all outputs 0 and `busy` = 0 for 10 cycles with no `start`.
2. `base_addr`=2, `length`=3, `out_ready`=1 → words 0x03, 0x04, 0x05 in cycles 3, 6, 9; `out_last` on 0x05; `done` in cycle 10.
3. Wrap and saturation: `base_addr`=6, `length`=12 → 8 words: 0x07, 0x08, 0x01 … 0x06; `out_last` only on 0x06.
4. Backpressure: `base_addr`=0, `length`=2, `out_ready` low for 5 cycles on word 1 → 0x01 held stable with no extra `rom_en`, then 0x02; `done` delayed by exactly 5 cycles.
5. `length`=0 → `done` in cycle 1, `out_valid` and `rom_en` never high. A second `start` asserted while `busy` is ignored.
6. Assert `reset_n` low while in HOLD → all outputs 0 immediately (asynchronously), no `done`. A fresh `base_addr`=5, `length`=1 then returns 0x06.
